// File: rtl/s1_cell_arbiter_if.sv
// Request/grant bundle between N control agents and the shared s1 cell arbiter.
//   req      : per-requester request level, held until that requester's ack
//   req_data : 7 operand bits per requester, slot i = {a0,b1,a1,d11,d10,d01,d00}
//   gnt      : one-hot grant, high while the operation is in flight
//   ack      : one-hot, one-cycle completion pulse
//   rdata    : cell result, valid with ack, otherwise 0
//   busy     : operation in flight
interface s1_cell_arbiter_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0]   req;
  logic [7*N-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [N-1:0]   ack;
  logic           rdata;
  logic           busy;

  modport master (output req, req_data, input gnt, ack, rdata, busy);
  modport slave  (input req, req_data, output gnt, ack, rdata, busy);
endinterface

// File: rtl/s1_cell_arbiter.sv
// Shares one s1 logic cell between N requesters: grants one requester, drives
// its latched operands into the cell, and returns the registered cell output
// with a one-cycle ack. The cell is cleared while the arbiter is idle.
// Ports:
//   clk   : rising-edge clock
//   clr_n : asynchronous active-low reset
//   bus   : s1_cell_arbiter_if.slave (req, req_data, gnt, ack, rdata, busy)
// Build option: define S1_ARB_RR_EN for round-robin arbitration; otherwise
// fixed priority with the lowest index winning.

// s1 cell: 4:1 mux with registered output and synchronous clear.
//   i_clr clears o_q at the clock edge; s0 = a0 & clr, s1 = a1 | b1.
module s1 (
  input  logic i_clk,
  input  logic i_clr,
  input  logic i_a0,
  input  logic i_b1,
  input  logic i_a1,
  input  logic i_d11,
  input  logic i_d10,
  input  logic i_d01,
  input  logic i_d00,
  output logic o_q
);
  logic w_s1;
  logic w_s0;
  logic w_mux;

  assign w_s1 = i_a1 | i_b1;
  assign w_s0 = i_a0 & i_clr;

  // Operand mux selected by {s1, s0}
  always_comb begin
    w_mux = i_d00;
    case ({w_s1, w_s0})
      2'b00:   w_mux = i_d00;
      2'b01:   w_mux = i_d01;
      2'b10:   w_mux = i_d10;
      default: w_mux = i_d11;
    endcase
  end

  // Output register, no reset: the arbiter clears it through i_clr while idle
  always_ff @(posedge i_clk) begin
    if (i_clr) o_q <= 1'b0;
    else       o_q <= w_mux;
  end
endmodule

module s1_cell_arbiter #(
  parameter int unsigned N = 4
) (
  input logic               clk,
  input logic               clr_n,
  s1_cell_arbiter_if.slave  bus
);
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned OW = 7;

  typedef struct packed {
    logic a0;
    logic b1;
    logic a1;
    logic d11;
    logic d10;
    logic d01;
    logic d00;
  } ops_t;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_CAPTURE} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [N-1:0]  r_gnt;
  ops_t          r_ops;
  logic          w_load;
  logic          w_done;
  logic          w_cell_clr;
  ops_t          w_cell_ops;
  logic          w_cell_q;
  logic [N-1:0]  w_ack;
  logic [PW-1:0] w_start;
  logic [PW-1:0] w_win_idx;
  logic [N-1:0]  w_win_oh;
  ops_t          w_slot [N];

  // Per-requester operand view
  for (genvar g = 0; g < N; g++) begin : g_slot
    assign w_slot[g] = ops_t'(bus.req_data[OW*g +: OW]);
  end

  // First requester found scanning upward from i_start, wrapping at N
  function automatic logic [PW-1:0] f_pick(input logic [N-1:0] i_req, input logic [PW-1:0] i_start);
    logic [PW-1:0] pick;
    logic [PW-1:0] idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = PW'((32'(i_start) + k) % N);
      if (!found && i_req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

`ifdef S1_ARB_RR_EN
  logic [PW-1:0] r_ptr;

  // Last winner; reset to N-1 so the first search starts at index 0
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n)      r_ptr <= PW'(N - 1);
    else if (w_load) r_ptr <= w_win_idx;
  end

  assign w_start = PW'((32'(r_ptr) + 32'd1) % N);
`else
  assign w_start = '0;
`endif

  assign w_win_idx = f_pick(bus.req, w_start);
  assign w_win_oh  = N'(1) << w_win_idx;

  // State register
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and cell drive; operands reach the cell only outside IDLE
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    w_cell_clr  = 1'b1;
    w_cell_ops  = '0;
    case (r_state)
      ST_IDLE: begin
        if (|bus.req) begin
          w_load      = 1'b1;
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        w_cell_clr  = 1'b0;
        w_cell_ops  = r_ops;
        w_state_nxt = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        w_cell_clr  = 1'b0;
        w_cell_ops  = r_ops;
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Winner and operands are captured only when a grant is issued from IDLE
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_gnt <= '0;
      r_ops <= '0;
    end else if (w_load) begin
      r_gnt <= w_win_oh;
      r_ops <= w_slot[w_win_idx];
    end else if (w_done) begin
      r_gnt <= '0;
    end
  end

  s1 u_cell (
    .i_clk (clk),
    .i_clr (w_cell_clr),
    .i_a0  (w_cell_ops.a0),
    .i_b1  (w_cell_ops.b1),
    .i_a1  (w_cell_ops.a1),
    .i_d11 (w_cell_ops.d11),
    .i_d10 (w_cell_ops.d10),
    .i_d01 (w_cell_ops.d01),
    .i_d00 (w_cell_ops.d00),
    .o_q   (w_cell_q)
  );

  // Outputs decoded from registered state only
  assign w_ack     = (r_state == ST_CAPTURE) ? r_gnt : '0;
  assign bus.gnt   = r_gnt;
  assign bus.ack   = w_ack;
  assign bus.busy  = (r_state != ST_IDLE);
  assign bus.rdata = (|w_ack) & w_cell_q;
endmodule

// File: tb/tb_s1_cell_arbiter.sv
// Directed bench for s1_cell_arbiter (N=4) with per-cycle protocol invariants.
module tb_s1_cell_arbiter;
  localparam int unsigned N = 4;

  logic clk = 1'b0;
  logic clr_n;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [3:0] exp_order [5];
  logic       exp_rd    [5];

  s1_cell_arbiter_if #(.N(N)) bus ();

  s1_cell_arbiter #(.N(N)) u_dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [27:0] slot(input int i, input logic [6:0] v);
    logic [27:0] t;
    t = 28'(v);
    return t << (7 * i);
  endfunction

  // One full operation from IDLE; requester drops req after its ack
  task automatic run_op(input string tag, input logic [3:0] rq, input logic [27:0] data,
                        input logic [3:0] exp_gnt, input logic exp_rdata);
    bus.req      = rq;
    bus.req_data = data;
    cyc();
    check({tag, "_issue_gnt"},  32'(bus.gnt),  32'(exp_gnt));
    check({tag, "_issue_busy"}, 32'(bus.busy), 32'd1);
    check({tag, "_issue_ack"},  32'(bus.ack),  32'd0);
    cyc();
    check({tag, "_cap_ack"},   32'(bus.ack),   32'(exp_gnt));
    check({tag, "_cap_rdata"}, 32'(bus.rdata), 32'(exp_rdata));
    bus.req = '0;
    cyc();
    check({tag, "_idle_gnt"},  32'(bus.gnt),  32'd0);
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_idle_ack"},  32'(bus.ack),  32'd0);
  endtask

  // Protocol invariants, sampled away from the active edge
  always @(negedge clk) begin
    check("inv_ack_onehot0", 32'($onehot0(bus.ack)), 32'd1);
    check("inv_ack_in_gnt",  32'(bus.ack & ~bus.gnt), 32'd0);
    if (bus.ack == '0) check("inv_rdata_zero", 32'(bus.rdata), 32'd0);
  end

  initial begin
`ifdef S1_ARB_RR_EN
    exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_rd    = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_rd    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    clr_n        = 1'b1;
    bus.req      = '0;
    bus.req_data = '0;
    #2;
    clr_n = 1'b0;
    cyc();
    check("rst_gnt",   32'(bus.gnt),   32'd0);
    check("rst_ack",   32'(bus.ack),   32'd0);
    check("rst_busy",  32'(bus.busy),  32'd0);
    check("rst_rdata", 32'(bus.rdata), 32'd0);
    cyc();
    clr_n = 1'b1;

    // Select 00 -> d00 = 1
    run_op("op0_d00", 4'b0001, slot(0, 7'b1001011), 4'b0001, 1'b1);
    // a1 = 1 -> d10 = 0
    run_op("op0_d10", 4'b0001, slot(0, 7'b1011011), 4'b0001, 1'b0);
    // a0 = 1 with b1 = 1 still selects d10, d11 ignored
    run_op("op2_a0", 4'b0100, slot(2, 7'b1100100), 4'b0100, 1'b1);

    // Fresh pointer, all four requesting continuously
    clr_n = 1'b0;
    cyc();
    check("rst2_busy", 32'(bus.busy), 32'd0);
    clr_n = 1'b1;
    bus.req      = 4'b1111;
    bus.req_data = slot(0, 7'b1001011) | slot(1, 7'b0000000) |
                   slot(2, 7'b1100100) | slot(3, 7'b0100001);
    for (int k = 0; k < 5; k++) begin
      cyc();
      check($sformatf("all%0d_gnt", k), 32'(bus.gnt), 32'(exp_order[k]));
      cyc();
      check($sformatf("all%0d_ack", k),   32'(bus.ack),   32'(exp_order[k]));
      check($sformatf("all%0d_rdata", k), 32'(bus.rdata), 32'(exp_rd[k]));
      cyc();
      check($sformatf("all%0d_idle", k), 32'(bus.busy), 32'd0);
    end
    bus.req      = '0;
    bus.req_data = '0;

    // Operands and req change during ISSUE; latched operands still used
    bus.req      = 4'b0010;
    bus.req_data = slot(1, 7'b0010100);
    cyc();
    check("late_gnt", 32'(bus.gnt), 32'd2);
    bus.req_data = '0;
    bus.req      = '0;
    cyc();
    check("late_ack",   32'(bus.ack),   32'd2);
    check("late_rdata", 32'(bus.rdata), 32'd1);
    cyc();
    check("late_idle", 32'(bus.busy), 32'd0);

    // Reset during CAPTURE
    bus.req      = 4'b1000;
    bus.req_data = slot(3, 7'b0010100);
    cyc();
    check("midrst_gnt", 32'(bus.gnt), 32'd8);
    cyc();
    check("midrst_cap_ack",   32'(bus.ack),   32'd8);
    check("midrst_cap_rdata", 32'(bus.rdata), 32'd1);
    bus.req = '0;
    #1;
    clr_n = 1'b0;
    #1;
    check("midrst_ack",   32'(bus.ack),   32'd0);
    check("midrst_gnt",   32'(bus.gnt),   32'd0);
    check("midrst_busy",  32'(bus.busy),  32'd0);
    check("midrst_rdata", 32'(bus.rdata), 32'd0);
    cyc();
    clr_n = 1'b1;
    run_op("post_rst", 4'b0100, slot(2, 7'b1100100), 4'b0100, 1'b1);

    cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
